// File: rtl/seq_shiftadder_mul_if.sv
// Operand/result handshake bundle for seq_shiftadder_mul.
// Valid/ready: a beat transfers on a rising edge where valid and ready are both high.
interface seq_shiftadder_mul_if #(
    parameter int WIDTH = 8
);
    logic               in_valid_i;
    logic               in_ready_o;
    logic [WIDTH-1:0]   multiplicand_i;
    logic [WIDTH-1:0]   multiplier_i;
    logic               halved_i;
    logic               signed_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [2*WIDTH-1:0] product_o;
    logic               busy_o;

    modport master (
        output in_valid_i, multiplicand_i, multiplier_i, halved_i, signed_i, out_ready_i,
        input  in_ready_o, out_valid_o, product_o, busy_o
    );

    modport slave (
        input  in_valid_i, multiplicand_i, multiplier_i, halved_i, signed_i, out_ready_i,
        output in_ready_o, out_valid_o, product_o, busy_o
    );
endinterface

// File: rtl/seq_shiftadder_mul.sv
// Iterative radix-2 shift-add multiplier: one WIDTH x WIDTH product or two
// independent WIDTH/2 lane products, signed or unsigned, one partial product per cycle.
module seq_shiftadder_mul #(
    parameter int WIDTH      = 8,
    parameter int ITER_CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    seq_shiftadder_mul_if.slave  bus,
    output logic [1:0]           dbg_state_o
);
    localparam int HALF   = WIDTH / 2;
    localparam int IDX_W  = $clog2(WIDTH);
    localparam int HIDX_W = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_mcand;
    logic [WIDTH-1:0]      r_mplier;
    logic                  r_halved;
    logic                  r_signed;
    logic [2*WIDTH-1:0]    r_acc;
    logic [2*WIDTH-1:0]    r_product;
    logic [ITER_CNT_W-1:0] r_cnt;
    logic                  r_out_valid;
    logic                  r_busy;

    logic                  w_accept;
    logic [ITER_CNT_W-1:0] w_iter;
    logic [ITER_CNT_W-1:0] w_load_iter;
    logic [IDX_W-1:0]      w_idx;
    logic [HIDX_W-1:0]     w_hidx;
    logic                  w_last;
    logic [2*WIDTH-1:0]    w_full_ext;
    logic [2*WIDTH-1:0]    w_full_pp;
    logic [2*WIDTH-1:0]    w_full_next;
    logic [2*WIDTH-1:0]    w_half_next;
    logic [2*WIDTH-1:0]    w_acc_next;

    // Counter runs ITER..1; the step index is how far it has come down.
    assign w_iter      = r_halved ? ITER_CNT_W'(HALF) : ITER_CNT_W'(WIDTH);
    assign w_load_iter = bus.halved_i ? ITER_CNT_W'(HALF) : ITER_CNT_W'(WIDTH);
    assign w_idx       = IDX_W'(w_iter - r_cnt);
    assign w_hidx      = HIDX_W'(w_iter - r_cnt);
    assign w_last      = (r_cnt == ITER_CNT_W'(1));

    assign w_full_ext  = {{WIDTH{r_signed & r_mcand[WIDTH-1]}}, r_mcand};
    assign w_full_pp   = w_full_ext << w_idx;

    always_comb begin
        w_full_next = r_acc;
        if (r_mplier[w_idx]) begin
            if (w_last && r_signed) w_full_next = r_acc - w_full_pp;
            else                    w_full_next = r_acc + w_full_pp;
        end
    end

    // Each lane has its own WIDTH-bit accumulator slice, so carries stay in-lane.
    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [HALF-1:0]  w_lmc;
        logic [HALF-1:0]  w_lmp;
        logic [WIDTH-1:0] w_lext;
        logic [WIDTH-1:0] w_lpp;
        logic [WIDTH-1:0] w_lacc;
        logic [WIDTH-1:0] w_lnext;

        assign w_lmc  = r_mcand[l*HALF +: HALF];
        assign w_lmp  = r_mplier[l*HALF +: HALF];
        assign w_lext = {{HALF{r_signed & w_lmc[HALF-1]}}, w_lmc};
        assign w_lpp  = w_lext << w_hidx;
        assign w_lacc = r_acc[l*WIDTH +: WIDTH];

        always_comb begin
            w_lnext = w_lacc;
            if (w_lmp[w_hidx]) begin
                if (w_last && r_signed) w_lnext = w_lacc - w_lpp;
                else                    w_lnext = w_lacc + w_lpp;
            end
        end

        assign w_half_next[l*WIDTH +: WIDTH] = w_lnext;
    end

    assign w_acc_next = r_halved ? w_half_next : w_full_next;

    // DONE hands its slot straight to a new beat when the result is taken.
    assign w_accept = bus.in_valid_i && bus.in_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_halved    <= 1'b0;
            r_signed    <= 1'b0;
            r_acc       <= '0;
            r_product   <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            r_mcand     <= bus.multiplicand_i;
            r_mplier    <= bus.multiplier_i;
            r_halved    <= bus.halved_i;
            r_signed    <= bus.signed_i;
            r_acc       <= '0;
            r_cnt       <= w_load_iter;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_BUSY;
        end else begin
            case (r_state)
                S_BUSY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - ITER_CNT_W'(1);
                    if (w_last) begin
                        r_product   <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_IDLE: begin
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready_i);
    assign bus.out_valid_o = r_out_valid;
    assign bus.product_o   = r_product;
    assign bus.busy_o      = r_busy;
    assign dbg_state_o     = r_state;
endmodule

// File: tb/tb_seq_shiftadder_mul.sv
// Directed bench for seq_shiftadder_mul at WIDTH=8: one task per scenario,
// inline comparisons against hand-computed products and latencies.
module tb_seq_shiftadder_mul;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         n_checks = 0;
    int         n_errors = 0;

    seq_shiftadder_mul_if #(.WIDTH(W)) bus ();

    seq_shiftadder_mul #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Full-mode vectors: a, b, signed, expected product
    logic [W-1:0]   f_a   [5] = '{8'h80, 8'hFF, 8'hFF, 8'h7F, 8'h00};
    logic [W-1:0]   f_b   [5] = '{8'h80, 8'hFF, 8'h03, 8'h80, 8'h5A};
    logic           f_s   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2*W-1:0] f_exp [5] = '{16'h4000, 16'hFE01, 16'hFFFD, 16'hC080, 16'h0000};

    // Halved-mode vectors
    logic [W-1:0]   h_a   [4] = '{8'h78, 8'hFF, 8'h88, 8'h88};
    logic [W-1:0]   h_b   [4] = '{8'hF8, 8'hFF, 8'h22, 8'h22};
    logic           h_s   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [2*W-1:0] h_exp [4] = '{16'hF940, 16'hE1E1, 16'h1010, 16'hF0F0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic h, input logic s);
        bus.multiplicand_i = a;
        bus.multiplier_i   = b;
        bus.halved_i       = h;
        bus.signed_i       = s;
        bus.in_valid_i     = 1'b1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.out_valid_o !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.in_ready_o !== 1'b1) begin
            n_errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready_o);
        end
        n_checks++;
        if (bus.out_valid_o !== 1'b0) begin
            n_errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid_o);
        end
        n_checks++;
        if (bus.busy_o !== 1'b0) begin
            n_errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o);
        end
        n_checks++;
        if (bus.product_o !== 16'h0000) begin
            n_errors++; $display("FAIL reset_product: got %h expected 0000", bus.product_o);
        end
        n_checks++;
        if (dbg_state !== 2'd0) begin
            n_errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full();
        int lat;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_beat(f_a[i], f_b[i], 1'b0, f_s[i]);
            tick();
            bus.in_valid_i = 1'b0;
            n_checks++;
            if (bus.busy_o !== 1'b1 || bus.in_ready_o !== 1'b0) begin
                n_errors++;
                $display("FAIL full_busy[%0d]: got busy=%b ready=%b expected busy=1 ready=0",
                         i, bus.busy_o, bus.in_ready_o);
            end
            wait_valid(lat);
            n_checks++;
            if (lat !== 8) begin
                n_errors++; $display("FAIL full_latency[%0d]: got %0d expected 8", i, lat);
            end
            n_checks++;
            if (bus.product_o !== f_exp[i]) begin
                n_errors++;
                $display("FAIL full_product[%0d]: got %h expected %h", i, bus.product_o, f_exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_halved();
        int lat;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_beat(h_a[i], h_b[i], 1'b1, h_s[i]);
            tick();
            bus.in_valid_i = 1'b0;
            wait_valid(lat);
            n_checks++;
            if (lat !== 4) begin
                n_errors++; $display("FAIL half_latency[%0d]: got %0d expected 4", i, lat);
            end
            n_checks++;
            if (bus.product_o !== h_exp[i]) begin
                n_errors++;
                $display("FAIL half_product[%0d]: got %h expected %h", i, bus.product_o, h_exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bus.out_ready_i = 1'b0;
        drive_beat(8'h12, 8'h34, 1'b0, 1'b0);
        tick();
        bus.in_valid_i = 1'b0;
        wait_valid(lat);
        n_checks++;
        if (bus.product_o !== 16'h03A8) begin
            n_errors++; $display("FAIL bp_product: got %h expected 03A8", bus.product_o);
        end
        for (int i = 0; i < 5; i++) begin
            drive_beat(8'(i * 8'h11 + 8'h05), 8'(8'hF0 - i), 1'(i % 2), 1'((i + 1) % 2));
            n_checks++;
            if (bus.in_ready_o !== 1'b0) begin
                n_errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready_o);
            end
            tick();
            n_checks++;
            if (bus.out_valid_o !== 1'b1 || bus.product_o !== 16'h03A8 || dbg_state !== 2'd2) begin
                n_errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b product=%h state=%0d expected 1/03A8/2",
                         i, bus.out_valid_o, bus.product_o, dbg_state);
            end
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        tick();
        n_checks++;
        if (bus.out_valid_o !== 1'b0 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL bp_release: got valid=%b state=%0d expected 0/0", bus.out_valid_o, dbg_state);
        end
        tick();
        n_checks++;
        if (bus.product_o !== 16'h03A8) begin
            n_errors++; $display("FAIL idle_retain: got %h expected 03A8", bus.product_o);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        bus.out_ready_i = 1'b1;
        drive_beat(8'h0F, 8'h0F, 1'b0, 1'b0);
        tick();
        drive_beat(8'hFF, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.in_ready_o !== 1'b0) begin
                n_errors++; $display("FAIL busy_in_ready[%0d]: got %b expected 0", i, bus.in_ready_o);
            end
            tick();
        end
        bus.in_valid_i = 1'b0;
        wait_valid(lat);
        n_checks++;
        if (lat + 3 !== 8) begin
            n_errors++; $display("FAIL busy_latency: got %0d expected 8", lat + 3);
        end
        n_checks++;
        if (bus.product_o !== 16'h00E1) begin
            n_errors++; $display("FAIL busy_product: got %h expected 00E1", bus.product_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.out_ready_i = 1'b1;
        drive_beat(8'h12, 8'h34, 1'b0, 1'b0);
        tick();
        bus.in_valid_i = 1'b0;
        wait_valid(lat);
        n_checks++;
        if (lat !== 8 || bus.product_o !== 16'h03A8) begin
            n_errors++;
            $display("FAIL b2b_first: got lat=%0d product=%h expected 8/03A8", lat, bus.product_o);
        end
        drive_beat(8'h35, 8'hE2, 1'b1, 1'b1);
        n_checks++;
        if (bus.in_ready_o !== 1'b1) begin
            n_errors++; $display("FAIL b2b_in_ready: got %b expected 1", bus.in_ready_o);
        end
        tick();
        bus.in_valid_i = 1'b0;
        n_checks++;
        if (dbg_state !== 2'd1 || bus.out_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_accept: got state=%0d valid=%b expected 1/0", dbg_state, bus.out_valid_o);
        end
        wait_valid(lat);
        n_checks++;
        if (lat !== 4 || bus.product_o !== 16'hFA0A) begin
            n_errors++;
            $display("FAIL b2b_second: got lat=%0d product=%h expected 4/FA0A", lat, bus.product_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        bus.out_ready_i = 1'b1;
        drive_beat(8'hFF, 8'hFF, 1'b0, 1'b0);
        tick();
        bus.in_valid_i = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.product_o !== 16'h0000
            || bus.busy_o !== 1'b0 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL midreset_state: got valid=%b ready=%b product=%h busy=%b state=%0d expected 0/1/0000/0/0",
                     bus.out_valid_o, bus.in_ready_o, bus.product_o, bus.busy_o, dbg_state);
        end
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid_o === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_errors++; $display("FAIL midreset_stale: got %0d valid cycles expected 0", seen);
        end
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.in_valid_i     = 1'b0;
        bus.multiplicand_i = '0;
        bus.multiplier_i   = '0;
        bus.halved_i       = 1'b0;
        bus.signed_i       = 1'b0;
        bus.out_ready_i    = 1'b1;

        test_reset();
        test_full();
        test_halved();
        test_backpressure();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seq_shiftadder_mul.md
Name: seq_shiftadder_mul

Overview:
Iterative radix-2 shift-add multiplier with runtime-selectable precision and signedness. It is the sequential, parametrised successor of the combinational 4-bit configurable shift-adder. In full mode it computes one WIDTH x WIDTH product; in halved mode it computes two packed WIDTH/2 x WIDTH/2 lane products in parallel. One partial product is retired per lane per cycle, which trades latency for area in the compute datapath.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4.
ITER_CNT_W, $clog2(WIDTH)+1, width of the internal step counter; derived, must not be overridden.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_ni  input  1  synchronous, active-low reset.
in_valid_i  input  1  operand beat valid.
in_ready_o  output  1  block can accept an operand beat.
multiplicand_i  input  WIDTH  multiplicand. In halved mode: lane0 = [WIDTH/2-1:0], lane1 = upper half.
multiplier_i  input  WIDTH  multiplier, packed the same way as multiplicand_i.
halved_i  input  1  0 = full precision, 1 = two halved-precision lanes; sampled at accept.
signed_i  input  1  1 = two's complement operands, 0 = unsigned; sampled at accept.
out_valid_o  output  1  product valid.
out_ready_i  input  1  consumer accepts the product.
product_o  output  2*WIDTH  full mode: full 2*WIDTH product. Halved mode: lane0 product in [WIDTH-1:0], lane1 product in [2*WIDTH-1:WIDTH].
busy_o  output  1  high in BUSY.

Behaviour:
- One clock domain. Reset is synchronous and active-low.
- Reset values: in_ready_o=1, out_valid_o=0, busy_o=0, product_o=0, state=IDLE, counter=0.
- FSM states are IDLE, BUSY and DONE.
- IDLE: in_ready_o=1. On in_valid_i & in_ready_o:
  - latch both operands, halved_i and signed_i;
  - clear the accumulator;
  - load the counter with ITER = WIDTH (full) or WIDTH/2 (halved);
  - move to BUSY.
- BUSY: one step per cycle, with step index i = 0..ITER-1.
  - Per lane: if multiplier bit i is set, add (multiplicand << i) to that lane's accumulator.
  - The multiplicand is sign-extended when signed, zero-extended when unsigned.
  - On the lane MSB step (i = ITER-1) with signed set, subtract the shifted multiplicand instead of adding it.
  - Accumulator width is 2*WIDTH in full mode and WIDTH per lane in halved mode.
  - In halved mode no carry or borrow crosses the lane boundary; all arithmetic is modulo the lane width.
  - After step ITER-1, go to DONE.
- DONE:
  - out_valid_o=1 and product_o holds the result, stable until out_ready_i.
  - On out_ready_i, return to IDLE.
  - In the same cycle, in_ready_o = out_ready_i, so a new beat can be accepted in that cycle (back-to-back) and the FSM goes straight to BUSY.
- Latency: if the accept edge is t, out_valid_o rises at edge t+ITER.
  - Full mode: 8 cycles at WIDTH=8.
  - Halved mode: 4 cycles at WIDTH=8.
  - Peak throughput is one result per ITER+1 cycles with out_ready_i tied high; back-to-back acceptance keeps it at ITER+1.
- in_ready_o=0 throughout BUSY. in_valid_i in BUSY is ignored, not queued.
- Changes to the operand, halved_i or signed_i inputs after accept have no effect on the in-flight operation.
- product_o retains the last result in IDLE. It is updated only on the transition into DONE.
- Zero operand: the block still takes the full ITER cycles; there is no early termination.
- Boundary case: the signed full-mode product (-2^(W-1))^2 must be exact with no overflow. The 2*WIDTH accumulator guarantees this.
- Reset asserted mid-operation (BUSY or DONE): the next edge forces the reset values and the in-flight result is discarded.

Test Plan:
- Full signed, WIDTH=8: multiplicand=0x80, multiplier=0x80 -> after 8 cycles product_o=0x4000, out_valid_o=1.
- Full unsigned: 0xFF x 0xFF -> product_o=0xFE01. Signed: 0xFF x 0x03 -> product_o=0xFFFD.
- Halved signed: multiplicand=0x78, multiplier=0xF8 -> after 4 cycles product_o=0xF940 (lane1 = 7 x -1 = 0xF9, lane0 = -8 x -8 = 0x40). Verify no carry crosses lanes.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> product_o and out_valid_o stay stable and in_ready_o=0. Toggle operand inputs meanwhile -> no effect.
- Back-to-back: out_ready_i=1, a second beat valid at the DONE cycle -> accepted in the same cycle, and the second result appears ITER cycles later.
- Reset: drop rst_ni at step 3 of a full operation -> the next cycle shows out_valid_o=0, in_ready_o=1, product_o=0, and no stale result is emitted.
